// File: rtl/ring_buffer_arbiter_n_pkg.sv
// Shared types and helpers for the N-channel ring-buffer arbiter.
package ring_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} arb_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int unsigned push_idx(input int unsigned ch);
    return ch;
  endfunction

  function automatic int unsigned pop_idx(input int unsigned ch, input int unsigned channels);
    return channels + ch;
  endfunction

endpackage

// File: rtl/ring_buffer_arbiter_n_if.sv
// Single-port memory bus shared by all channels; master side is the arbiter.
interface ring_buffer_arbiter_n_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/ring_buffer_arbiter_n_ring_pointer_set.sv
// One channel's committed/tentative write and read pointers with commit/rollback.
module ring_pointer_set
    import ring_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  wr_inc,
    input  logic                  rd_inc,
    input  logic                  drop,
    input  logic                  wr_commit,
    input  logic                  wr_rollback,
    input  logic                  rd_commit,
    input  logic                  rd_rollback,
    output logic [DEPTH_LOG2-1:0] wr_off,
    output logic [DEPTH_LOG2-1:0] rd_off,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  overflow
);
    localparam int unsigned PtrW = ptr_width(DEPTH_LOG2);
    localparam logic [PtrW-1:0] Cap = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d, wr_next;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, rd_tmp_q, rd_tmp_d, rd_next;
    logic            ovf_q, ovf_d;

    // Commit sees the post-increment value; rollback beats both commit and increment.
    always_comb begin
        wr_next  = wr_inc ? wr_tmp_q + PtrW'(1) : wr_tmp_q;
        rd_next  = rd_inc ? rd_tmp_q + PtrW'(1) : rd_tmp_q;
        wr_tmp_d = wr_rollback ? wr_ptr_q : wr_next;
        rd_tmp_d = rd_rollback ? rd_ptr_q : rd_next;
        wr_ptr_d = (wr_commit && !wr_rollback) ? wr_next : wr_ptr_q;
        rd_ptr_d = (rd_commit && !rd_rollback) ? rd_next : rd_ptr_q;
        ovf_d    = wr_rollback ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            wr_tmp_q <= '0;
            rd_ptr_q <= '0;
            rd_tmp_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_tmp_q <= wr_tmp_d;
            rd_ptr_q <= rd_ptr_d;
            rd_tmp_q <= rd_tmp_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_off   = wr_tmp_q[DEPTH_LOG2-1:0];
    assign rd_off   = rd_tmp_q[DEPTH_LOG2-1:0];
    assign full     = (wr_tmp_q - rd_ptr_q) == Cap;
    assign empty    = rd_tmp_q == wr_ptr_q;
    assign used     = wr_ptr_q - rd_ptr_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/ring_buffer_arbiter_n.sv
// N-channel ring-buffer controller: round-robin arbitration of push/pop ports onto one memory bus.
module ring_buffer_arbiter_n
    import ring_arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                               clk,
    input  logic                               nRst,
    input  logic [CHANNELS-1:0]                push_req,
    input  logic [CHANNELS-1:0][DATA_W-1:0]    push_data,
    output logic [CHANNELS-1:0]                push_done,
    input  logic [CHANNELS-1:0]                pop_req,
    output logic [CHANNELS-1:0][DATA_W-1:0]    pop_data,
    output logic [CHANNELS-1:0]                pop_done,
    input  logic [CHANNELS-1:0]                wr_commit,
    input  logic [CHANNELS-1:0]                wr_rollback,
    input  logic [CHANNELS-1:0]                rd_commit,
    input  logic [CHANNELS-1:0]                rd_rollback,
    output logic [CHANNELS-1:0][DEPTH_LOG2:0]  used,
    output logic [CHANNELS-1:0]                overflow,
    ring_buffer_arbiter_n_if.master            mem
);
    localparam int unsigned NReq = 2 * CHANNELS;
    localparam int unsigned ReqW = $clog2(NReq);
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    arb_state_e state_q, state_d;
    logic [ReqW-1:0] prio_q, prio_d, sel_q, sel_d, win;
    logic [CHANNELS-1:0] push_done_q, push_done_d, pop_done_q, pop_done_d;
    logic [CHANNELS-1:0][DATA_W-1:0] pop_data_q, pop_data_d;
    logic [CHANNELS-1:0] full, empty, drop, wr_inc, rd_inc;
    logic [CHANNELS-1:0][DEPTH_LOG2-1:0] wr_off, rd_off;
    logic [NReq-1:0] eligible;
    logic found, win_pop, sel_pop;
    logic [ChW-1:0] win_ch, sel_ch;
    int unsigned idx;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ptr
        ring_pointer_set #(.DEPTH_LOG2(DEPTH_LOG2)) u_ptr (
            .clk        (clk),
            .nRst       (nRst),
            .wr_inc     (wr_inc[i]),
            .rd_inc     (rd_inc[i]),
            .drop       (drop[i]),
            .wr_commit  (wr_commit[i]),
            .wr_rollback(wr_rollback[i]),
            .rd_commit  (rd_commit[i]),
            .rd_rollback(rd_rollback[i]),
            .wr_off     (wr_off[i]),
            .rd_off     (rd_off[i]),
            .full       (full[i]),
            .empty      (empty[i]),
            .used       (used[i]),
            .overflow   (overflow[i])
        );
    end

    // Requester layout follows push_idx/pop_idx; a requester whose done is high is masked.
    always_comb begin
        eligible = {pop_req & ~pop_done_q & ~empty, push_req & ~push_done_q};
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NReq; k++) begin
            idx = (32'(prio_q) + k) % NReq;
            if (!found && eligible[ReqW'(idx)]) begin
                found = 1'b1;
                win   = ReqW'(idx);
            end
        end
        win_pop = 32'(win) >= pop_idx(0, CHANNELS);
        win_ch  = win_pop ? ChW'(32'(win) - pop_idx(0, CHANNELS)) : ChW'(32'(win) - push_idx(0));
        sel_pop = 32'(sel_q) >= pop_idx(0, CHANNELS);
        sel_ch  = sel_pop ? ChW'(32'(sel_q) - pop_idx(0, CHANNELS)) : ChW'(32'(sel_q) - push_idx(0));
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        sel_d       = sel_q;
        push_done_d = '0;
        pop_done_d  = '0;
        pop_data_d  = pop_data_q;
        drop        = '0;
        wr_inc      = '0;
        rd_inc      = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    prio_d = ReqW'((32'(win) + 1) % NReq);
                    sel_d  = win;
                    if (!win_pop && full[win_ch]) begin
                        // Full push: acknowledge and discard without touching memory.
                        push_done_d[win_ch] = 1'b1;
                        drop[win_ch]        = 1'b1;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (mem.mem_ack) begin
                    state_d = StDone;
                    if (sel_pop) begin
                        pop_done_d[sel_ch] = 1'b1;
                        pop_data_d[sel_ch] = mem.mem_rdata;
                    end else begin
                        push_done_d[sel_ch] = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (sel_pop) rd_inc[sel_ch] = 1'b1;
                else         wr_inc[sel_ch] = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= StIdle;
            prio_q      <= '0;
            sel_q       <= '0;
            push_done_q <= '0;
            pop_done_q  <= '0;
            pop_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            push_done_q <= push_done_d;
            pop_done_q  <= pop_done_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign push_done     = push_done_q;
    assign pop_done      = pop_done_q;
    assign pop_data      = pop_data_q;
    assign mem.mem_req   = (state_q == StAccess);
    assign mem.mem_we    = mem.mem_req && !sel_pop;
    assign mem.mem_addr  = mem.mem_req ?
                           ADDR_W'({sel_ch, sel_pop ? rd_off[sel_ch] : wr_off[sel_ch]}) : '0;
    assign mem.mem_wdata = mem.mem_we ? push_data[sel_ch] : '0;
endmodule

// File: tb/tb_ring_buffer_arbiter_n.sv
// Scoreboard bench for ring_buffer_arbiter_n with two channels of depth four.
module tb_ring_buffer_arbiter_n;
    localparam int unsigned CH = 2, DW = 16, DL = 2, AW = 16;
    localparam int KWrCommit = 0, KWrRollback = 1, KRdCommit = 2, KRdRollback = 3;

    typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } acc_t;
    typedef struct { int ch; logic [15:0] data; } pop_t;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic [CH-1:0] push_req, push_done, pop_req, pop_done;
    logic [CH-1:0] wr_commit, wr_rollback, rd_commit, rd_rollback, overflow;
    logic [CH-1:0][DW-1:0] push_data, pop_data;
    logic [CH-1:0][DL:0] used;
    logic [15:0] mem_arr [0:7];

    int n_checks = 0, n_fail = 0, n_acc = 0;
    acc_t exp_mem[$];
    pop_t exp_pop[$];
    int order[$];
    int unsigned m_wr_ptr[CH], m_wr_tmp[CH], m_rd_ptr[CH], m_rd_tmp[CH];
    logic [15:0] m_data[CH][4];

    ring_buffer_arbiter_n_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

    ring_buffer_arbiter_n #(.CHANNELS(CH), .DATA_W(DW), .DEPTH_LOG2(DL), .ADDR_W(AW)) dut (
        .clk(clk), .nRst(nRst),
        .push_req(push_req), .push_data(push_data), .push_done(push_done),
        .pop_req(pop_req), .pop_data(pop_data), .pop_done(pop_done),
        .wr_commit(wr_commit), .wr_rollback(wr_rollback),
        .rd_commit(rd_commit), .rd_rollback(rd_rollback),
        .used(used), .overflow(overflow), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    // Memory acks one cycle after mem_req rises.
    always @(posedge clk or negedge nRst) begin
        if (!nRst) mem_bus.mem_ack <= 1'b0;
        else       mem_bus.mem_ack <= mem_bus.mem_req & ~mem_bus.mem_ack;
    end
    always @(posedge clk) begin
        if (mem_bus.mem_req && mem_bus.mem_ack && mem_bus.mem_we)
            mem_arr[mem_bus.mem_addr[2:0]] <= mem_bus.mem_wdata;
    end
    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr[2:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nRst === 1'b1) begin
            if (mem_bus.mem_req && mem_bus.mem_ack) begin
                n_acc++;
                check_eq("mem_expected", 32'(exp_mem.size() != 0), 1);
                if (exp_mem.size() != 0) begin
                    acc_t e;
                    e = exp_mem.pop_front();
                    check_eq("mem_we", 32'(mem_bus.mem_we), 32'(e.we));
                    check_eq("mem_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
                    if (e.we) check_eq("mem_wdata", 32'(mem_bus.mem_wdata), 32'(e.data));
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (pop_done[c]) begin
                    check_eq("pop_expected", 32'(exp_pop.size() != 0), 1);
                    if (exp_pop.size() != 0) begin
                        pop_t p;
                        p = exp_pop.pop_front();
                        check_eq("pop_ch", c, p.ch);
                        check_eq("pop_data", 32'(pop_data[c]), 32'(p.data));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        nRst = 1'b0;
        push_req = '0; pop_req = '0; push_data = '0;
        wr_commit = '0; wr_rollback = '0; rd_commit = '0; rd_rollback = '0;
        for (int c = 0; c < CH; c++) begin
            m_wr_ptr[c] = 0; m_wr_tmp[c] = 0; m_rd_ptr[c] = 0; m_rd_tmp[c] = 0;
        end
        exp_mem.delete();
        exp_pop.delete();
        repeat (2) @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic expect_push(input int ch, input logic [15:0] d);
        if (((m_wr_tmp[ch] - m_rd_ptr[ch]) % 8) != 4) begin
            exp_mem.push_back('{we: 1'b1, addr: 16'(ch * 4 + m_wr_tmp[ch] % 4), data: d});
            m_data[ch][m_wr_tmp[ch] % 4] = d;
            m_wr_tmp[ch] = (m_wr_tmp[ch] + 1) % 8;
        end
    endtask

    task automatic expect_pop(input int ch);
        exp_mem.push_back('{we: 1'b0, addr: 16'(ch * 4 + m_rd_tmp[ch] % 4), data: 16'h0});
        exp_pop.push_back('{ch: ch, data: m_data[ch][m_rd_tmp[ch] % 4]});
        m_rd_tmp[ch] = (m_rd_tmp[ch] + 1) % 8;
    endtask

    task automatic do_push(input int ch, input logic [15:0] d, output int lat);
        expect_push(ch, d);
        @(negedge clk);
        push_data[ch] = d;
        push_req[ch]  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!push_done[ch] && lat < 40);
        check_eq("push_done_seen", 32'(push_done[ch]), 1);
        push_req[ch] = 1'b0;
    endtask

    task automatic do_pop(input int ch, output int lat);
        expect_pop(ch);
        @(negedge clk);
        pop_req[ch] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pop_done[ch] && lat < 40);
        check_eq("pop_done_seen", 32'(pop_done[ch]), 1);
        pop_req[ch] = 1'b0;
    endtask

    task automatic strobe(input int kind, input int ch);
        @(negedge clk);
        case (kind)
            KWrCommit:   begin wr_commit[ch] = 1'b1;   m_wr_ptr[ch] = m_wr_tmp[ch]; end
            KWrRollback: begin wr_rollback[ch] = 1'b1; m_wr_tmp[ch] = m_wr_ptr[ch]; end
            KRdCommit:   begin rd_commit[ch] = 1'b1;   m_rd_ptr[ch] = m_rd_tmp[ch]; end
            default:     begin rd_rollback[ch] = 1'b1; m_rd_tmp[ch] = m_rd_ptr[ch]; end
        endcase
        @(negedge clk);
        wr_commit = '0; wr_rollback = '0; rd_commit = '0; rd_rollback = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n0;
        for (int i = 0; i < 8; i++) mem_arr[i] = 16'h0;
        do_reset();
        check_eq("rst_push_done", 32'(push_done), 0);
        check_eq("rst_pop_done", 32'(pop_done), 0);
        check_eq("rst_pop_data", 32'(pop_data), 0);
        check_eq("rst_used", 32'(used), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_mem_req", 32'(mem_bus.mem_req), 0);
        check_eq("rst_mem_addr", 32'(mem_bus.mem_addr), 0);

        // Basic push/commit/pop/commit with 3-cycle latency.
        do_push(0, 16'h00A1, lat);
        check_eq("a_push_lat", lat, 3);
        check_eq("a_used_tentative", 32'(used[0]), 0);
        strobe(KWrCommit, 0);
        check_eq("a_used_commit", 32'(used[0]), 1);
        do_pop(0, lat);
        check_eq("a_pop_lat", lat, 3);
        check_eq("a_pop_data", 32'(pop_data[0]), 32'h00A1);
        strobe(KRdCommit, 0);
        check_eq("a_used_drain", 32'(used[0]), 0);

        // All requesters at once from reset priority; pops wait for committed data.
        do_reset();
        expect_push(0, 16'h00B0);
        expect_push(1, 16'h00B1);
        @(negedge clk);
        push_data = {16'h00B1, 16'h00B0};
        push_req = 2'b11;
        pop_req  = 2'b11;
        order.delete();
        for (int cyc = 0; cyc < 60 && (push_req != 0 || order.size() < 2); cyc++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (push_done[c]) begin order.push_back(c); push_req[c] = 1'b0; end
                if (pop_done[c]) begin order.push_back(2 + c); pop_req[c] = 1'b0; end
            end
        end
        repeat (8) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pop_done[c]) order.push_back(2 + c);
        end
        check_eq("c_pops_pending", order.size(), 2);
        @(negedge clk);
        wr_commit = 2'b11;
        m_wr_ptr[0] = m_wr_tmp[0];
        m_wr_ptr[1] = m_wr_tmp[1];
        expect_pop(0);
        expect_pop(1);
        @(negedge clk);
        wr_commit = '0;
        for (int cyc = 0; cyc < 60 && pop_req != 0; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pop_done[c]) begin
                order.push_back(2 + c);
                pop_req[c] = 1'b0;
            end
        end
        check_eq("c_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) check_eq("c_grant_order", order[i], i);

        // Overflow on a full channel, then rollback.
        do_reset();
        for (int i = 0; i < 4; i++) do_push(1, 16'h1000 + 16'(i), lat);
        n0 = n_acc;
        do_push(1, 16'hDEAD, lat);
        check_eq("b_drop_lat", lat, 1);
        check_eq("b_no_mem_access", n_acc, n0);
        check_eq("b_overflow_set", 32'(overflow[1]), 1);
        strobe(KWrRollback, 1);
        check_eq("b_overflow_clr", 32'(overflow[1]), 0);
        check_eq("b_used_rb", 32'(used[1]), 0);
        do_push(1, 16'h2222, lat);
        strobe(KWrCommit, 1);
        check_eq("b_used_after", 32'(used[1]), 1);

        // Read rollback replays the same word.
        do_reset();
        do_push(0, 16'h0D01, lat);
        do_push(0, 16'h0D02, lat);
        strobe(KWrCommit, 0);
        check_eq("d_used", 32'(used[0]), 2);
        do_pop(0, lat);
        strobe(KRdRollback, 0);
        do_pop(0, lat);
        check_eq("d_replay", 32'(pop_data[0]), 32'h0D01);
        check_eq("d_used_kept", 32'(used[0]), 2);

        // Fill and drain three times across pointer wrap.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) do_push(0, 16'($urandom), lat);
            strobe(KWrCommit, 0);
            check_eq("e_used_full", 32'(used[0]), 4);
            for (int i = 0; i < 4; i++) do_pop(0, lat);
            strobe(KRdCommit, 0);
            check_eq("e_used_empty", 32'(used[0]), 0);
        end

        // Asynchronous reset in the middle of an access.
        do_push(1, 16'h0F0F, lat);
        strobe(KWrCommit, 1);
        check_eq("f_used_pre", 32'(used[1]), 1);
        @(negedge clk);
        push_data[0] = 16'h55AA;
        push_req[0]  = 1'b1;
        for (int i = 0; i < 10 && !mem_bus.mem_req; i++) @(negedge clk);
        check_eq("f_req_up", 32'(mem_bus.mem_req), 1);
        #1 nRst = 1'b0;
        #1;
        check_eq("f_req_async_drop", 32'(mem_bus.mem_req), 0);
        check_eq("f_used_rst", 32'(used), 0);
        check_eq("f_done_rst", 32'({push_done, pop_done}), 0);
        check_eq("f_pop_data_rst", 32'(pop_data), 0);
        do_reset();
        do_push(0, 16'h0077, lat);
        check_eq("f_push_lat", lat, 3);

        repeat (4) @(negedge clk);
        check_eq("sb_mem_drained", exp_mem.size(), 0);
        check_eq("sb_pop_drained", exp_pop.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
